mat_sum_acc: RTL and testbench



---
 rtl/cnn_pkg.sv | 8 +
 rtl/addfp16.sv | 50 +++++
 rtl/mat_sum_acc.sv | 54 +++++
 tb/tb_mat_sum_acc.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: FP16 constants and accumulator state encoding shared by the CNN tail blocks.
package cnn_pkg;
  localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
  localparam logic [15:0] FP16_NEG_INF  = 16'hFC00;
  localparam logic [15:0] FP16_POS_INF  = 16'h7C00;
  localparam logic [15:0] FP16_QNAN     = 16'h7E00;
  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} acc_state_t;
endpackage

// File: rtl/addfp16.sv
// addfp16: combinational IEEE FP16 adder, round-to-nearest-even, saturating to Inf, subnormals supported.
module addfp16
  import cnn_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);
  logic        a_nan, b_nan, a_inf, b_inf, swap, sub, st, up, sg;
  logic [15:0] l, r;
  logic [4:0]  e_l, e_s, d;
  logic [10:0] m_l, m_s;
  logic [13:0] sh, al, n;
  logic [14:0] s;
  logic [5:0]  lz, sft, e, ef;
  logic [11:0] m;
  assign a_nan = &a[14:10] && |a[9:0];
  assign b_nan = &b[14:10] && |b[9:0];
  assign a_inf = &a[14:10] && !(|a[9:0]);
  assign b_inf = &b[14:10] && !(|b[9:0]);
  // l is the larger magnitude, so the effective subtraction never goes negative
  assign swap = b[14:0] > a[14:0];
  assign l    = swap ? b : a;
  assign r    = swap ? a : b;
  assign e_l  = |l[14:10] ? l[14:10] : 5'd1;
  assign e_s  = |r[14:10] ? r[14:10] : 5'd1;
  assign m_l  = {|l[14:10], l[9:0]};
  assign m_s  = {|r[14:10], r[9:0]};
  assign d    = e_l - e_s;
  assign sub  = l[15] ^ r[15];
  always_comb begin
    sh = {m_s, 3'b000} >> d;
    st = d >= 5'd14 ? |m_s : |({m_s, 3'b000} & ((14'd1 << d) - 14'd1));
    al = {sh[13:1], sh[0] | st};
    s  = sub ? {1'b0, m_l, 3'b000} - {1'b0, al} : {1'b0, m_l, 3'b000} + {1'b0, al};
    lz = 6'd14;
    for (int i = 0; i < 14; i++) if (s[i]) lz = 6'(13 - i);
    sft = lz < {1'b0, e_l} - 6'd1 ? lz : {1'b0, e_l} - 6'd1;
    n   = s[14] ? {s[14:2], s[1] | s[0]} : s[13:0] << sft;
    e   = s[14] ? {1'b0, e_l} + 6'd1 : {1'b0, e_l} - sft;
    up  = n[2] & (n[3] | n[1] | n[0]);
    m   = {1'b0, n[13:3]} + {11'd0, up};
    ef  = m[11] ? e + 6'd1 : (m[10] ? e : 6'd0);
    sg  = s == 15'd0 ? l[15] & r[15] : l[15];
  end
  assign sum = (a_nan || b_nan || (a_inf && b_inf && sub)) ? FP16_QNAN :
               a_inf ? a : b_inf ? b :
               ef >= 6'd31 ? (sg ? FP16_NEG_INF : FP16_POS_INF) :
               {sg, ef[4:0], m[11] ? m[10:1] : m[9:0]};
endmodule

// File: rtl/mat_sum_acc.sv
// mat_sum_acc: per-map streaming FP16 sum over N_ELEMS beats, emitted as a one-cycle valid pulse.
module mat_sum_acc
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_MATS     = 10,
  parameter int N_ELEMS    = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clr,
  input  logic [N_MATS-1:0][DATA_WIDTH-1:0]  in_data,
  input  logic                               in_valid,
  input  logic                               in_last,
  output logic                               in_ready,
  output logic [N_MATS-1:0][DATA_WIDTH-1:0]  out_sum,
  output logic                               out_valid,
  output logic                               frame_err
);
  localparam int CNT_W = $clog2(N_ELEMS);
  acc_state_t                        state;
  logic [CNT_W-1:0]                  cnt;
  logic [N_MATS-1:0][DATA_WIDTH-1:0] acc, sum_w;
  logic                              fire, last;
  assign in_ready  = state != EMIT;
  assign out_valid = state == EMIT;
  assign fire      = in_valid && in_ready;
  assign last      = cnt == CNT_W'(N_ELEMS - 1);
  for (genvar i = 0; i < N_MATS; i++) begin : g_add
    addfp16 u_add (.a(acc[i]), .b(in_data[i]), .sum(sum_w[i]));
  end
  // in_last is only audited; the beat counter alone decides frame boundaries
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= {N_MATS{FP16_POS_ZERO}};
      out_sum   <= {N_MATS{FP16_POS_ZERO}};
      frame_err <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= {N_MATS{FP16_POS_ZERO}};
      frame_err <= 1'b0;
    end else if (fire) begin
      frame_err <= frame_err | (in_last ^ last);
      acc       <= last ? {N_MATS{FP16_POS_ZERO}} : sum_w;
      cnt       <= last ? '0 : cnt + CNT_W'(1);
      state     <= last ? EMIT : ACCUM;
      if (last) out_sum <= sum_w;
    end else if (state == EMIT) begin
      state <= IDLE;
    end
endmodule

// File: tb/tb_mat_sum_acc.sv
// tb_mat_sum_acc: directed self-checking bench for mat_sum_acc with hand-computed FP16 sums.
module tb_mat_sum_acc;
  localparam int DW = 16, NM = 10, NE = 16;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [NM-1:0][DW-1:0] in_data = '0;
  logic [NM-1:0][DW-1:0] out_sum;
  logic in_ready, out_valid, frame_err;
  int n_cmp = 0, n_err = 0;

  mat_sum_acc #(.DATA_WIDTH(DW), .N_MATS(NM), .N_ELEMS(NE)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_sum(out_sum), .out_valid(out_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic v, input logic l);
    in_valid = v;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic ones_frame(input string tag);
    in_data = '0;
    in_data[0] = 16'h3C00;
    for (int b = 0; b < NE; b++) begin
      beat(1'b1, b == NE - 1);
      if (b < NE - 1) chk({tag, "_early_ov"}, out_valid, 1'b0);
    end
    chk({tag, "_ov"}, out_valid, 1'b1);
    chk({tag, "_sum0"}, out_sum[0], 16'h4C00);
  endtask

  initial begin
    int got, cyc, nrdy, pulses;
    logic rdy, v;
    // reset state
    #12;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_sum0", out_sum[0], 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // basic sum
    in_data = '0;
    in_data[0] = 16'h3C00;
    in_data[3] = 16'h4000;
    for (int b = 0; b < NE; b++) begin
      beat(1'b1, b == NE - 1);
      if (b < NE - 1) chk("basic_early_ov", out_valid, 1'b0);
    end
    chk("basic_ov", out_valid, 1'b1);
    chk("basic_ready", in_ready, 1'b0);
    chk("basic_sum0", out_sum[0], 16'h4C00);
    chk("basic_sum3", out_sum[3], 16'h5000);
    chk("basic_sum1", out_sum[1], 16'h0000);
    chk("basic_ferr", frame_err, 1'b0);
    beat(1'b0, 1'b0);
    chk("basic_pulse", out_valid, 1'b0);
    chk("basic_hold", out_sum[0], 16'h4C00);
    // back-to-back with in_valid held high for two frames
    got = 0; nrdy = 0; pulses = 0;
    in_data = '0;
    for (int k = 0; k < 2 * NE + 2; k++) begin
      in_data[0] = got < NE ? 16'h3800 : 16'h3C00;
      rdy = in_ready;
      in_valid = 1'b1;
      in_last = (got % NE) == NE - 1;
      @(posedge clk);
      #1;
      if (rdy) got++;
      else nrdy++;
      if (out_valid) begin
        pulses++;
        chk("b2b_sum0", out_sum[0], pulses == 1 ? 16'h4800 : 16'h4C00);
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("b2b_accepted", 16'(got), 16'd32);
    chk("b2b_not_ready", 16'(nrdy), 16'd2);
    chk("b2b_pulses", 16'(pulses), 16'd2);
    chk("b2b_ferr", frame_err, 1'b0);
    // sign cancellation, overflow, NaN, subnormal, negative
    for (int b = 0; b < NE; b++) begin
      in_data = '0;
      in_data[1] = b[0] ? 16'hBC00 : 16'h3C00;
      in_data[2] = 16'h7BFF;
      in_data[4] = 16'h7E00;
      in_data[5] = 16'h0001;
      in_data[7] = 16'hBC00;
      beat(1'b1, b == NE - 1);
    end
    chk("sign_ov", out_valid, 1'b1);
    chk("sign_cancel", out_sum[1], 16'h0000);
    chk("sign_ovf", out_sum[2], 16'h7C00);
    chk("sign_nan", (out_sum[4][14:10] == 5'h1F) && (out_sum[4][9:0] != 10'd0), 1'b1);
    chk("sign_subn", out_sum[5], 16'h0010);
    chk("sign_neg", out_sum[7], 16'hCC00);
    chk("sign_zero", out_sum[9], 16'h0000);
    // random gaps
    in_data = '0;
    in_data[0] = 16'h3C00;
    in_data[3] = 16'h4000;
    got = 0; cyc = 0;
    while (got < NE && cyc < 200) begin
      v = 1'($urandom_range(0, 1));
      beat(v, got == NE - 1);
      if (v) got++;
      if (got < NE) chk("gap_early_ov", out_valid, 1'b0);
      cyc++;
    end
    chk("gap_count", 16'(got), 16'(NE));
    chk("gap_ov", out_valid, 1'b1);
    chk("gap_sum0", out_sum[0], 16'h4C00);
    chk("gap_sum3", out_sum[3], 16'h5000);
    beat(1'b0, 1'b0);
    // framing error: early in_last on beat 5
    in_data = '0;
    in_data[0] = 16'h3C00;
    for (int b = 0; b < NE; b++) begin
      beat(1'b1, b == 4 || b == NE - 1);
      if (b == 4) chk("ferr_set", frame_err, 1'b1);
      if (b < NE - 1) chk("ferr_early_ov", out_valid, 1'b0);
    end
    chk("ferr_ov", out_valid, 1'b1);
    chk("ferr_sum0", out_sum[0], 16'h4C00);
    chk("ferr_sticky", frame_err, 1'b1);
    beat(1'b0, 1'b0);
    // clr after 7 beats, with a discarded beat in the clr cycle
    in_data[0] = 16'h4000;
    for (int b = 0; b < 7; b++) beat(1'b1, 1'b0);
    clr = 1'b1;
    beat(1'b1, 1'b0);
    clr = 1'b0;
    chk("clr_ov", out_valid, 1'b0);
    chk("clr_ferr", frame_err, 1'b0);
    chk("clr_hold", out_sum[0], 16'h4C00);
    ones_frame("clr_next");
    chk("clr_next_ferr", frame_err, 1'b0);
    beat(1'b0, 1'b0);
    // asynchronous reset mid-frame
    in_data[0] = 16'h4000;
    for (int b = 0; b < 5; b++) beat(1'b1, b == 1);
    chk("pre_rst_ferr", frame_err, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_ov", out_valid, 1'b0);
    chk("arst_ferr", frame_err, 1'b0);
    chk("arst_sum0", out_sum[0], 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ones_frame("arst_next");
    beat(1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
